// File: rtl/spi_flash_pkg.sv
// ---------------------------------------------------------------------------
// spi_flash_pkg
// Shared types and constants for the SPI flash reader.
//   state_e    : controller state encoding
//   CMD_*      : flash opcodes
//   CMD_OPCODE : opcode issued by this build. It is FAST READ when
//                SPI_FAST_READ_EN is defined and plain READ otherwise.
// ---------------------------------------------------------------------------
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    GAP
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         ADDR_BITS     = 24;

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD_OPCODE = CMD_FAST_READ;
`else
  localparam logic [7:0] CMD_OPCODE = CMD_READ;
`endif

endpackage

// File: rtl/spi_flash_reader_if.sv
// ---------------------------------------------------------------------------
// spi_flash_reader_if
// Groups the request and read-data handshakes of the reader.
//   req_valid/req_ready/req_addr/req_len : read request (start addr, byte count)
//   data_valid/data_ready/data_out       : returned byte stream
// Modports:
//   master : user logic that issues requests and consumes bytes
//   slave  : the reader
// ---------------------------------------------------------------------------
interface spi_flash_reader_if #(
  parameter int LEN_W = 16
) ();

  logic             req_valid;
  logic             req_ready;
  logic [23:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic             data_valid;
  logic             data_ready;
  logic [7:0]       data_out;

  modport master (
    output req_valid, req_addr, req_len, data_ready,
    input  req_ready, data_valid, data_out
  );

  modport slave (
    input  req_valid, req_addr, req_len, data_ready,
    output req_ready, data_valid, data_out
  );

endinterface

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen
// Generates flash_clk. A divider counts CLK_DIV system clocks, and each
// terminal count toggles flash_clk.
//   clock, resetb : system clock, asynchronous active-low reset
//   en_i          : run the clock. When low, the divider clears and
//                   flash_clk is forced low.
//   hold_i        : freeze the divider. This only takes effect while
//                   flash_clk is low, so the clock always parks low.
//   flash_clk_o   : SPI clock (idles low)
//   rise_o/fall_o : one-cycle strobes, high in the cycle whose closing edge
//                   drives flash_clk high / low
// ---------------------------------------------------------------------------
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic resetb,
  input  logic en_i,
  input  logic hold_i,
  output logic flash_clk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             terminal, freeze;

  assign terminal = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign freeze   = hold_i && !clk_q;

  // NOTE: every output of this process gets a default before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    rise_o = 1'b0;
    fall_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (!freeze) begin
      if (terminal) begin
        cnt_d  = '0;
        clk_d  = !clk_q;
        rise_o = !clk_q;
        fall_o = clk_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign flash_clk_o = clk_q;

endmodule

// File: rtl/spi_flash_reader.sv
// ---------------------------------------------------------------------------
// spi_flash_reader
// SPI mode-0 read initiator for a serial NOR flash. A request gives a start
// address and a byte count. The reader sends the opcode and a 24-bit address,
// then streams the returned bytes out over a valid/ready handshake.
// Define SPI_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks.
// Ports:
//   clock, resetb : system clock, asynchronous active-low reset
//   bus           : request / data handshakes (spi_flash_reader_if.slave)
//   busy          : transaction in progress, including the csb-high gap
//   flash_csb     : chip select, active low
//   flash_clk     : SPI clock, idles low
//   flash_io0     : MOSI
//   flash_io1     : MISO
// ---------------------------------------------------------------------------
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CSB_HIGH = 4,
  parameter int LEN_W    = 16
) (
  input  logic                clock,
  input  logic                resetb,
  spi_flash_reader_if.slave   bus,
  output logic                busy,
  output logic                flash_csb,
  output logic                flash_clk,
  output logic                flash_io0,
  input  logic                flash_io1
);

  localparam int GAP_W = (CSB_HIGH > 0) ? $clog2(CSB_HIGH + 1) : 1;

  state_e           state_q, state_d;
  logic [31:0]      shift_out_q, shift_out_d;
  logic [7:0]       shift_in_q, shift_in_d;
  logic [7:0]       data_out_q, data_out_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             csb_q, csb_d;
  logic             data_valid_q, data_valid_d;
  logic             byte_done_q, byte_done_d;
  logic             sclk_en, sclk_hold, sclk_rise, sclk_fall, req_fire;

  assign bus.req_ready = (state_q == IDLE) && !data_valid_q;
  assign req_fire      = bus.req_valid && bus.req_ready;

  assign sclk_en = state_q inside {CMD, ADDR, DUMMY, DATA};
  // Withhold the 8th rising edge of a byte while the previous byte still
  // waits for the consumer, so the shift register is never overwritten.
  assign sclk_hold = (state_q == DATA) && (bit_cnt_q == 5'd7) &&
                     data_valid_q && !bus.data_ready;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clock       (clock),
    .resetb      (resetb),
    .en_i        (sclk_en),
    .hold_i      (sclk_hold),
    .flash_clk_o (flash_clk),
    .rise_o      (sclk_rise),
    .fall_o      (sclk_fall)
  );

  always_comb begin
    state_d      = state_q;
    shift_out_d  = shift_out_q;
    shift_in_d   = shift_in_q;
    data_out_d   = data_out_q;
    bit_cnt_d    = bit_cnt_q;
    len_d        = len_q;
    gap_cnt_d    = gap_cnt_q;
    csb_d        = csb_q;
    data_valid_d = data_valid_q;
    byte_done_d  = 1'b0;

    // Output register: a completed byte is presented one cycle after capture.
    if (byte_done_q) begin
      data_out_d   = shift_in_q;
      data_valid_d = 1'b1;
    end else if (data_valid_q && bus.data_ready) begin
      data_valid_d = 1'b0;
    end

    // MOSI advances while flash_clk goes low. Zeros fill in behind the
    // address, so dummy and data phases drive io0 low.
    if (sclk_fall) begin
      shift_out_d = {shift_out_q[30:0], 1'b0};
    end

    case (state_q)
      IDLE: begin
        csb_d = 1'b1;
        if (req_fire) begin
          len_d = bus.req_len;
          if (bus.req_len != '0) begin
            state_d     = CMD;
            csb_d       = 1'b0;
            shift_out_d = {CMD_OPCODE, bus.req_addr};
            bit_cnt_d   = '0;
          end
        end
      end
      CMD: begin
        if (sclk_rise) begin
          if (bit_cnt_q == 5'd7) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
`ifdef SPI_FAST_READ_EN
            state_d = DUMMY;
`else
            state_d = DATA;
`endif
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
`ifdef SPI_FAST_READ_EN
      DUMMY: begin
        if (sclk_rise) begin
          if (bit_cnt_q == 5'd7) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
`endif
      DATA: begin
        if (sclk_rise && (len_q != '0)) begin
          shift_in_d = {shift_in_q[6:0], flash_io1};
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d   = '0;
            len_d       = len_q - LEN_W'(1);
            byte_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        // After the last capture, wait for flash_clk to park low, then close.
        if (sclk_fall && (len_q == '0)) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        csb_d = 1'b1;
        if (gap_cnt_q == GAP_W'(CSB_HIGH)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      shift_out_q  <= '0;
      shift_in_q   <= '0;
      data_out_q   <= '0;
      bit_cnt_q    <= '0;
      len_q        <= '0;
      gap_cnt_q    <= '0;
      csb_q        <= 1'b1;
      data_valid_q <= 1'b0;
      byte_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_out_q  <= shift_out_d;
      shift_in_q   <= shift_in_d;
      data_out_q   <= data_out_d;
      bit_cnt_q    <= bit_cnt_d;
      len_q        <= len_d;
      gap_cnt_q    <= gap_cnt_d;
      csb_q        <= csb_d;
      data_valid_q <= data_valid_d;
      byte_done_q  <= byte_done_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign flash_csb      = csb_q;
  assign flash_io0      = shift_out_q[31];
  assign bus.data_valid = data_valid_q;
  assign bus.data_out   = data_out_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_reader
// Scoreboard bench for spi_flash_reader. A behavioural SPI flash model
// answers reads from a 256-byte image. Stimulus pushes the expected bytes and
// expected (header, edge count) per csb window into queues. Independent
// monitors pop and compare these when the DUT hands out a byte or releases
// csb.
// ---------------------------------------------------------------------------
module tb_spi_flash_reader;

  localparam int CLK_DIV  = 2;
  localparam int CSB_HIGH = 4;
  localparam int LEN_W    = 16;
`ifdef SPI_FAST_READ_EN
  localparam int         HDR = 40;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int         HDR = 32;
  localparam logic [7:0] OPC = 8'h03;
`endif

  typedef struct {
    logic [31:0] hdr;
    int          edges;
  } txn_t;

  logic clock = 1'b0;
  logic resetb;
  logic busy, flash_csb, flash_clk, flash_io0;
  logic flash_io1 = 1'b0;

  int   checks   = 0;
  int   failures = 0;
  logic mon_en     = 1'b0;
  logic mon_ignore = 1'b0;

  logic [7:0]  mem [256];
  logic [7:0]  burst_tbl [16] = '{8'h93, 8'h01, 8'h00, 8'h13, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                                  8'h5A, 8'hC3, 8'h3C, 8'hFF, 8'h80, 8'h7E, 8'h42, 8'h24};
  logic [7:0]  exp_data_q [$];
  txn_t        exp_txn_q [$];
  txn_t        cur_txn;

  int          f_bits = 0;
  logic [31:0] f_hdr  = '0;
  int          acc_cnt  = 0;
  int          low_run  = 0;
  int          high_run = 0;
  logic        prev_csb = 1'b1;

  spi_flash_reader_if #(.LEN_W(LEN_W)) bus ();

  spi_flash_reader #(
    .CLK_DIV  (CLK_DIV),
    .CSB_HIGH (CSB_HIGH),
    .LEN_W    (LEN_W)
  ) dut (
    .clock     (clock),
    .resetb    (resetb),
    .bus       (bus),
    .busy      (busy),
    .flash_csb (flash_csb),
    .flash_clk (flash_clk),
    .flash_io0 (flash_io0),
    .flash_io1 (flash_io1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- flash model ----------------
  // csb falling restarts the bit count; each rising flash_clk samples MOSI.
  always @(posedge flash_clk or negedge flash_csb) begin
    if (flash_clk === 1'b1) begin
      if (flash_csb === 1'b0) begin
        if (f_bits < 32) f_hdr = {f_hdr[30:0], flash_io0};
        f_bits++;
      end
    end else begin
      f_bits = 0;
      f_hdr  = '0;
    end
  end

  // Read data shifts out on falling edges once the header has been received.
  always @(negedge flash_clk) begin
    if (flash_csb === 1'b0 && f_bits >= HDR) begin
      int         idx;
      logic [7:0] b;
      idx       = f_bits - HDR;
      b         = mem[8'(f_hdr[7:0] + 8'(idx / 8))];
      flash_io1 = b[7 - (idx % 8)];
    end
  end

  // ---------------- monitors ----------------
  always @(posedge flash_csb) begin
    if (mon_en && !mon_ignore) begin
      if (exp_txn_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL txn_unexpected: csb window with %0d edges, none outstanding", f_bits);
      end else begin
        cur_txn = exp_txn_q.pop_front();
        check("mosi_header", 64'(f_hdr), 64'(cur_txn.hdr));
        check("sclk_edges", 64'(f_bits), 64'(cur_txn.edges));
      end
    end
  end

  always @(negedge clock) begin
    if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) begin
      acc_cnt++;
      if (exp_data_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL data_unexpected: got 0x%02h with no byte outstanding", bus.data_out);
      end else begin
        check("data_byte", 64'(bus.data_out), 64'(exp_data_q.pop_front()));
      end
    end
  end

  always @(negedge clock) begin
    if (flash_clk === 1'b1) low_run = 0;
    else                    low_run++;
  end

  always @(negedge clock) begin
    if (flash_csb === 1'b1) begin
      high_run++;
    end else if (flash_csb === 1'b0) begin
      if (prev_csb && mon_en)
        check("csb_gap", 64'((high_run < CSB_HIGH) ? high_run : CSB_HIGH), 64'(CSB_HIGH));
      high_run = 0;
    end
    prev_csb = flash_csb;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_txn(input logic [23:0] a, input int n);
    exp_txn_q.push_back('{hdr: {OPC, a}, edges: HDR + 8 * n});
  endtask

  task automatic send_req(input logic [23:0] a, input logic [LEN_W-1:0] n, output int waited);
    waited = 0;
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = n;
    while (!bus.req_ready && waited < 5000) begin
      @(posedge clock); #1;
      waited++;
    end
    check("req_accept_timeout", 64'(waited >= 5000), 64'd0);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || bus.data_valid || exp_data_q.size() != 0) && t < 5000) begin
      @(negedge clock);
      t++;
    end
    check("idle_timeout", 64'(t >= 5000), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int waited, start, t, csb_low, val_cnt;
    resetb         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.data_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 16; i++)  mem[i] = burst_tbl[i];
    mem[16] = 8'hA5;

    repeat (3) @(posedge clock); #1;
    check("rst_csb",        64'(flash_csb),      64'd1);
    check("rst_sclk",       64'(flash_clk),      64'd0);
    check("rst_io0",        64'(flash_io0),      64'd0);
    check("rst_req_ready",  64'(bus.req_ready),  64'd1);
    check("rst_data_valid", 64'(bus.data_valid), 64'd0);
    check("rst_data_out",   64'(bus.data_out),   64'd0);
    check("rst_busy",       64'(busy),           64'd0);
    resetb = 1'b1;
    mon_en = 1'b1;

    // Single byte, then a burst back to back to exercise the csb gap.
    push_txn(24'h000010, 1);
    exp_data_q.push_back(8'hA5);
    send_req(24'h000010, 16'd1, waited);
    check("busy_after_accept", 64'(busy), 64'd1);

    push_txn(24'h000000, 16);
    for (int i = 0; i < 16; i++) exp_data_q.push_back(burst_tbl[i]);
    send_req(24'h000000, 16'd16, waited);
    wait_idle();

    // Backpressure: stall the consumer right after byte 0.
    push_txn(24'h000040, 4);
    exp_data_q.push_back(8'h1A);
    exp_data_q.push_back(8'h1B);
    exp_data_q.push_back(8'h18);
    exp_data_q.push_back(8'h19);
    start = acc_cnt;
    send_req(24'h000040, 16'd4, waited);
    t = 0;
    while (acc_cnt == start && t < 2000) begin
      @(negedge clock);
      t++;
    end
    check("bp_first_byte", 64'(acc_cnt - start), 64'd1);
    @(posedge clock); #1;
    bus.data_ready = 1'b0;
    repeat (150) @(negedge clock);
    check("bp_sclk_low_run", 64'((low_run < 40) ? low_run : 40), 64'd40);
    check("bp_csb_held",     64'(flash_csb),      64'd0);
    check("bp_valid_held",   64'(bus.data_valid), 64'd1);
    @(posedge clock); #1;
    bus.data_ready = 1'b1;
    wait_idle();

    // Zero-length request: accepted at once, no flash activity.
    send_req(24'h000100, 16'd0, waited);
    check("len0_wait", 64'(waited), 64'd0);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_req_ready", 64'(bus.req_ready), 64'd1);
    csb_low = 0;
    val_cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (flash_csb !== 1'b1) csb_low++;
      if (bus.data_valid !== 1'b0) val_cnt++;
    end
    check("len0_csb_low_cycles", 64'(csb_low), 64'd0);
    check("len0_valid_cycles",   64'(val_cnt), 64'd0);

    // Reset in the middle of the address phase.
    send_req(24'h000020, 16'd2, waited);
    t = 0;
    while (f_bits < 20 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    check("rst_mid_edge20", 64'((f_bits >= 20) ? 20 : f_bits), 64'd20);
    mon_ignore = 1'b1;
    #2;
    resetb = 1'b0;
    #1;
    check("rst_mid_csb",        64'(flash_csb),      64'd1);
    check("rst_mid_sclk",       64'(flash_clk),      64'd0);
    check("rst_mid_io0",        64'(flash_io0),      64'd0);
    check("rst_mid_data_valid", 64'(bus.data_valid), 64'd0);
    check("rst_mid_busy",       64'(busy),           64'd0);
    check("rst_mid_req_ready",  64'(bus.req_ready),  64'd1);
    repeat (3) @(posedge clock); #1;
    resetb = 1'b1;
    @(posedge clock); #1;
    mon_ignore = 1'b0;

    push_txn(24'h000020, 2);
    exp_data_q.push_back(8'h7A);
    exp_data_q.push_back(8'h7B);
    send_req(24'h000020, 16'd2, waited);
    wait_idle();
    repeat (4) @(negedge clock);

    check("data_queue_left", 64'(exp_data_q.size()), 64'd0);
    check("txn_queue_left",  64'(exp_txn_q.size()),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
